// File: rtl/bin2onehot_walker.sv
// Streaming binary-to-one-hot walker: each command (start index, beats-1) emits registered
// one-hot beats walking upward with wrap. Optional BIN2ONEHOT_THERMO_OUT_EN adds out_thermo.
module bin2onehot_walker #(
  parameter  int DATA_WIDTH = 8,
  parameter  int LEN_W      = 4,
  localparam int IW         = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IW-1:0]         in_idx,
  input  logic [LEN_W-1:0]      in_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_onehot,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  busy
`ifdef BIN2ONEHOT_THERMO_OUT_EN
  ,
  output logic [DATA_WIDTH-1:0] out_thermo
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] f_onehot(input logic [IW-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    v = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      v[i] = (idx == IW'(i));
    end
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_thermo(input logic [IW-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    v = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      v[i] = ({1'b0, idx} >= (IW+1)'(i));
    end
    return v;
  endfunction

  // Indices at or above DATA_WIDTH only exist when DATA_WIDTH is not a power of two.
  function automatic logic f_out_of_range(input logic [IW-1:0] idx);
    return ({1'b0, idx} >= (IW+1)'(DATA_WIDTH));
  endfunction

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt, w_idx_adv;
  logic [LEN_W-1:0]      r_rem, w_rem_nxt;
  logic [DATA_WIDTH-1:0] r_onehot, w_onehot_nxt;
  logic [DATA_WIDTH-1:0] r_thermo, w_thermo_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_load, w_adv, w_oor;

  assign in_ready = (r_state == S_IDLE) || ((r_state == S_RUN) && r_last && out_ready);

  // Next-state and next-beat computation: load a command, advance a beat, or hold.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_rem_nxt    = r_rem;
    w_onehot_nxt = r_onehot;
    w_thermo_nxt = r_thermo;
    w_last_nxt   = r_last;
    w_err_nxt    = r_err;
    w_load       = 1'b0;
    w_adv        = 1'b0;
    w_oor        = f_out_of_range(in_idx);
    w_idx_adv    = (r_idx == IW'(DATA_WIDTH - 1)) ? {IW{1'b0}} : r_idx + IW'(1);

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (r_rem != {LEN_W{1'b0}}) begin
            w_adv = 1'b1;
          end else if (in_valid) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_idx_nxt    = in_idx;
      w_rem_nxt    = w_oor ? {LEN_W{1'b0}} : in_len;
      w_onehot_nxt = w_oor ? {DATA_WIDTH{1'b0}} : f_onehot(in_idx);
      w_thermo_nxt = w_oor ? {DATA_WIDTH{1'b0}} : f_thermo(in_idx);
      w_last_nxt   = w_oor || (in_len == {LEN_W{1'b0}});
      w_err_nxt    = w_oor;
    end else if (w_adv) begin
      w_idx_nxt    = w_idx_adv;
      w_rem_nxt    = r_rem - LEN_W'(1);
      w_onehot_nxt = f_onehot(w_idx_adv);
      w_thermo_nxt = f_thermo(w_idx_adv);
      w_last_nxt   = (r_rem == LEN_W'(1));
      w_err_nxt    = 1'b0;
    end else begin
      w_idx_nxt    = r_idx;
    end
  end

  // State and beat registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= {IW{1'b0}};
      r_rem    <= {LEN_W{1'b0}};
      r_onehot <= {DATA_WIDTH{1'b0}};
      r_thermo <= {DATA_WIDTH{1'b0}};
      r_last   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_rem    <= w_rem_nxt;
      r_onehot <= w_onehot_nxt;
      r_thermo <= w_thermo_nxt;
      r_last   <= w_last_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign out_valid  = (r_state == S_RUN);
  assign busy       = (r_state == S_RUN);
  assign out_onehot = r_onehot;
  assign out_idx    = r_idx;
  assign out_last   = r_last;
  assign out_err    = r_err;

`ifdef BIN2ONEHOT_THERMO_OUT_EN
  assign out_thermo = r_thermo;
`else
  logic w_unused_thermo;
  assign w_unused_thermo = ^r_thermo;
`endif

endmodule

// File: tb/tb_bin2onehot_walker.sv
// Scoreboard bench: two walkers (widths 8 and 6) share clock/reset; a model queues expected
// beats per command and a negedge monitor compares every presented beat against the queue front.
module tb_bin2onehot_walker;

  typedef struct packed {
    logic [7:0] oh;
    logic [7:0] th;
    logic [2:0] idx;
    logic       last;
    logic       err;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv[2];
  logic       ir[2];
  logic [2:0] ii[2];
  logic [3:0] il[2];
  logic       ov[2];
  logic       ordy[2];
  logic [2:0] oi[2];
  logic       ol[2];
  logic       oe[2];
  logic       ob[2];
  logic [7:0] oh8;
  logic [5:0] oh6;
  logic [7:0] th8;
  logic [5:0] th6;
  int         rmode[2];
  beat_t      q0[$];
  beat_t      q1[$];
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  bin2onehot_walker #(.DATA_WIDTH(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_idx(ii[0]),
    .in_len(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_onehot(oh8),
    .out_idx(oi[0]), .out_last(ol[0]), .out_err(oe[0]), .busy(ob[0])
`ifdef BIN2ONEHOT_THERMO_OUT_EN
    , .out_thermo(th8)
`endif
  );

  bin2onehot_walker #(.DATA_WIDTH(6), .LEN_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_idx(ii[1]),
    .in_len(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_onehot(oh6),
    .out_idx(oi[1]), .out_last(ol[1]), .out_err(oe[1]), .busy(ob[1])
`ifdef BIN2ONEHOT_THERMO_OUT_EN
    , .out_thermo(th6)
`endif
  );

`ifndef BIN2ONEHOT_THERMO_OUT_EN
  assign th8 = 8'h00;
  assign th6 = 6'h00;
`endif

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h want %0h", name, k, $time, act, exp);
    end
  endtask

  // Reference model: beat b of a command visits (idx+b) mod width; out-of-range is a lone error beat.
  task automatic push_exp(input int k, input int idx, input int len);
    int    dw;
    int    i;
    beat_t e;
    dw = (k == 0) ? 8 : 6;
    if (idx >= dw) begin
      e = '{oh: 8'h00, th: 8'h00, idx: 3'(idx), last: 1'b1, err: 1'b1};
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end else begin
      for (int b = 0; b <= len; b++) begin
        i = (idx + b) % dw;
        e.oh   = 8'(1 << i);
        e.th   = 8'((1 << (i + 1)) - 1);
        e.idx  = 3'(i);
        e.last = (b == len);
        e.err  = 1'b0;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  // Called one step after a rising edge; returns one step after the accepting edge.
  task automatic send(input int k, input int idx, input int len);
    bit done;
    done  = 1'b0;
    iv[k] = 1'b1;
    ii[k] = 3'(idx);
    il[k] = 4'(len);
    push_exp(k, idx, len);
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (ir[k]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    iv[k] = 1'b0;
    if (!done) chk("send_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !ov[0] && !ov[1]) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input int k);
    beat_t      e;
    bit         have;
    logic [7:0] oh_a;
    logic [7:0] th_a;
    oh_a = (k == 0) ? oh8 : {2'b00, oh6};
    th_a = (k == 0) ? th8 : {2'b00, th6};
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (ov[k]) begin
      chk("busy_run", k, 32'(ob[k]), 32'd1);
      if (!have) begin
        chk("unexpected_beat", k, 32'd1, 32'd0);
      end else begin
        e = (k == 0) ? q0[0] : q1[0];
        chk("onehot", k, 32'(oh_a), 32'(e.oh));
        chk("idx", k, 32'(oi[k]), 32'(e.idx));
        chk("last", k, 32'(ol[k]), 32'(e.last));
        chk("err", k, 32'(oe[k]), 32'(e.err));
`ifdef BIN2ONEHOT_THERMO_OUT_EN
        chk("thermo", k, 32'(th_a), 32'(e.th));
`endif
        chk("in_ready_run", k, 32'(ir[k]), 32'(e.last && ordy[k]));
        if (ordy[k]) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end else begin
      chk("busy_idle", k, 32'(ob[k]), 32'd0);
      chk("in_ready_idle", k, 32'(ir[k]), 32'd1);
    end
  endtask

  // Monitor: compare whatever each DUT presents against its scoreboard front.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) check_port(k);
    end
  end

  // out_ready driver: 0 = low, 1 = high, otherwise random per cycle.
  initial begin
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        case (rmode[k])
          0: ordy[k] = 1'b0;
          1: ordy[k] = 1'b1;
          default: ordy[k] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ii[k] = 3'd0; il[k] = 4'd0; rmode[k] = 1;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(ov[k]), 32'd0);
      chk("rst_busy", k, 32'(ob[k]), 32'd0);
      chk("rst_idx", k, 32'(oi[k]), 32'd0);
      chk("rst_last", k, 32'(ol[k]), 32'd0);
      chk("rst_err", k, 32'(oe[k]), 32'd0);
    end
    chk("rst_onehot", 0, 32'(oh8), 32'd0);
    chk("rst_onehot", 1, 32'(oh6), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat, then idle on the following cycle.
    send(0, 3, 0);
    @(negedge clk);
    @(negedge clk);
    chk("single_then_idle", 0, 32'(ob[0]), 32'd0);
    @(posedge clk); #1;

    send(0, 6, 3);
    wait_drain();

    // Stall three cycles on the first beat.
    rmode[0] = 0;
    send(0, 2, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_valid", 0, 32'(ov[0]), 32'd1);
    rmode[0] = 1;
    wait_drain();

    // Back-to-back commands must produce three consecutive beats.
    fork
      begin
        send(0, 1, 1);
        send(0, 5, 0);
      end
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("b2b_no_bubble", 0, 32'(ov[0]), 32'd1);
        end
        @(negedge clk);
        chk("b2b_end", 0, 32'(ov[0]), 32'd0);
      end
    join
    wait_drain();

    send(1, 7, 5);
    @(negedge clk);
    @(negedge clk);
    chk("oor_idle", 1, 32'(ov[1]), 32'd0);
    @(posedge clk); #1;

    // Reset mid-command after three beats.
    send(0, 0, 7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, 32'(ov[0]), 32'd0);
    chk("async_rst_onehot", 0, 32'(oh8), 32'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_quiet", 0, 32'(ov[0]), 32'd0);

    // Randomized traffic on both widths with random backpressure.
    rmode[0] = 2;
    rmode[1] = 2;
    fork
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      end
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      end
    join
    rmode[0] = 1;
    rmode[1] = 1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
